complex_acc: RTL
================

COMPLEX_ACC -- requirements
Module: complex_acc

Interface
REQ-001 SHALL have parameter LEN, default 16: samples per frame, legal range 1..256.
REQ-002 SHALL have parameter ACC_W, default 24: accumulator width in bits, legal range 17..32.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the sample on in_re/in_im is present this cycle.
REQ-006 SHALL have port in_re, input, 16 bits: real part of the product from the upstream complex multiplier, two's complement.
REQ-007 SHALL have port in_im, input, 16 bits: imaginary part of that product, two's complement.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept a sample this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: frame result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out_re, output, ACC_W bits: real frame sum, two's complement.
REQ-012 SHALL have port out_im, output, ACC_W bits: imaginary frame sum, two's complement.
REQ-013 SHALL have port out_ovf, output, 1 bit: sticky flag, set if either sum overflowed during the frame.

Function
REQ-014 SHALL implement FSM states IDLE, ACC and HOLD.
REQ-015 SHALL count a sample as accepted only when in_valid=1 and in_ready=1 in the same cycle; cycles with in_valid=0 SHALL NOT change state, count or sums.
REQ-016 SHALL drive in_ready=1 in IDLE and ACC, and in_ready=0 in HOLD.
REQ-017 In IDLE, an accepted sample SHALL load the sign-extended in_re/in_im into the sums (no add), set count=1 and clear ovf; the FSM SHALL go to HOLD if LEN=1, otherwise to ACC.
REQ-018 In ACC, each accepted sample SHALL add sign-extended in_re/in_im to the sums and increment count.
REQ-019 In ACC, acceptance with count=LEN-1 SHALL move the FSM to HOLD.
REQ-020 SHALL assert out_valid exactly one cycle after the last sample of a frame is accepted.
REQ-021 In HOLD, out_valid=1 and out_re, out_im and out_ovf SHALL stay stable until out_ready=1.
REQ-022 A HOLD cycle with out_ready=1 SHALL complete the handshake and return the FSM to IDLE, with out_valid=0 from the next cycle.
REQ-023 SHALL NOT accept a sample in the same cycle as the output handshake; the next frame starts at the earliest one cycle later.
REQ-024 Sums SHALL wrap modulo 2^ACC_W.
REQ-025 ovf SHALL be set when the sign bits of both addends are equal and the sign bit of the result differs, on either lane; it SHALL hold until the next frame start.
REQ-026 out_re/out_im SHALL show the live sums in all states; they are qualified only by out_valid.

Reset
REQ-027 While rst=1, the FSM SHALL be IDLE; count, sums, out_re, out_im, out_ovf and out_valid SHALL be 0; in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-028 rst SHALL override everything: a partial frame, or a HOLD result not yet handshaked, SHALL be discarded without producing out_valid.

Structure
REQ-029 Shared package complex_pkg SHALL hold: constant DATA_W=16; the FSM state typedef (IDLE=2'd0, ACC=2'd1, HOLD=2'd2).
REQ-030 SHALL use one sub-module, complex_acc_lane, instantiated twice (re, im), containing: sign-extension, load/add mux, accumulator register, overflow detect.
REQ-031 FSM and counter SHALL live in complex_acc only; count width SHALL be clog2(LEN+1).

Verification
REQ-032 Scenario: LEN=4; 4 back-to-back samples (re=368, im=470), out_ready=1 -> out_valid one cycle after 4th sample; out_re=1472, out_im=1880, out_ovf=0.
REQ-033 Scenario: LEN=4; in_re=16'hFFFB (-5), in_im=3, with in_valid bubbles between samples -> out_re=-20 sign-extended to ACC_W, out_im=12; bubbles do not advance count.
REQ-034 Scenario: backpressure; out_ready=0 for 3 cycles in HOLD while in_valid=1 -> outputs stable, in_ready=0, no sample absorbed; out_ready=1 -> IDLE next cycle.
REQ-035 Scenario: rst pulsed after 2 of 4 samples, then 4 samples of (1,1) -> no out_valid for the aborted frame; result out_re=4, out_im=4.
REQ-036 Scenario: ACC_W=17, LEN=4, in_re=16'h7FFF x4 -> out_ovf=1, out_re=17'h1FFFC (wrapped).
REQ-037 Scenario: LEN=1; sample (7,-2) -> out_valid the next cycle with out_re=7, out_im=-2; back-to-back frames alternate accept/handshake cycles.

Source files
------------

// File: rtl/complex_pkg.sv
// Shared definitions for the complex frame accumulator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   DATA_W  - width of each incoming product lane
//   state_e - frame FSM encoding (IDLE, ACC, HOLD)
package complex_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/complex_acc_lane.sv
// One accumulator lane: sign-extends a sample, then loads it or adds it
// into a wrapping sum while tracking a sticky two's-complement overflow.
// Latency: sum/ovf update on the clock edge after load_i/add_i.
// Backpressure: none; the lane acts on every load_i/add_i it is given.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   load_i   - start a new frame: sum <= sample, ovf cleared
//   add_i    - accumulate: sum <= sum + sample, ovf sticky
//   din_i    - signed DATA_W-bit sample
//   sum_o    - live running sum (ACC_W bits, wraps)
//   ovf_o    - sticky overflow seen since the last load
module complex_acc_lane
  import complex_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W-1:0] din_ext;
  logic [ACC_W-1:0] add_res;
  logic             ovf_q, ovf_d;

  assign din_ext = {{(ACC_W-DATA_W){din_i[DATA_W-1]}}, din_i};
  assign add_res = sum_q + din_ext;

  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (load_i) begin
      sum_d = din_ext;
      ovf_d = 1'b0;
    end else if (add_i) begin
      sum_d = add_res;
      // Same-sign addends producing an opposite-sign result means the
      // true sum left the representable range.
      if ((sum_q[ACC_W-1] == din_ext[ACC_W-1]) &&
          (add_res[ACC_W-1] != sum_q[ACC_W-1])) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum_o = sum_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/complex_acc.sv
// Complex frame accumulator: sums LEN complex samples per frame and
// presents the frame sum plus a sticky overflow flag.
// Latency: out_valid rises one cycle after the last sample of a frame.
// Backpressure: in_ready drops while a result waits in HOLD for out_ready.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - sample handshake; in_re/in_im signed 16-bit
//   out_valid/out_ready - result handshake; out_re/out_im are live sums
//   out_ovf             - overflow on either lane during the frame
module complex_acc
  import complex_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_re,
  output logic [ACC_W-1:0]  out_im,
  output logic              out_ovf
);

  localparam int                CNT_W    = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             load;
  logic             add;
  logic             ovf_re, ovf_im;

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    add     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = (LEN == 1) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          add   = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // The handshake cycle never accepts a sample; in_ready is low here.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  complex_acc_lane #(.ACC_W(ACC_W)) u_lane_re (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .add_i  (add),
    .din_i  (in_re),
    .sum_o  (out_re),
    .ovf_o  (ovf_re)
  );

  complex_acc_lane #(.ACC_W(ACC_W)) u_lane_im (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .add_i  (add),
    .din_i  (in_im),
    .sum_o  (out_im),
    .ovf_o  (ovf_im)
  );

  // Gated by rst so a pending result is never offered while reset is held.
  assign out_valid = (state_q == HOLD) && !rst;
  assign out_ovf   = ovf_re | ovf_im;

endmodule
